// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: forwarding selects plus stall/flush control.
// Tracks its own shadow copy of the E/M/W destination-register fields.
module hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegDstD,
    input  logic                  RegWriteD,
    input  logic                  MemtoRegD,
    input  logic                  BranchD,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushE,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE
);

    logic [REG_ADDR_W-1:0] rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic                  reg_write_e, mem_to_reg_e;
    logic                  reg_write_m, mem_to_reg_m;
    logic                  reg_write_w;

    logic                  stall;
    logic                  lw_stall, branch_stall;
    logic                  d_hits_e, d_hits_m;

    // Register 0 is hardwired, so a zero source address never counts as a match.
    function automatic logic hits(input logic [REG_ADDR_W-1:0] dest,
                                  input logic [REG_ADDR_W-1:0] src);
        return (src != '0) && (dest == src);
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        if (reg_write_m && hits(write_reg_m, rs_e))
            ForwardAE = 2'b10;
        else if (reg_write_w && hits(write_reg_w, rs_e))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (reg_write_m && hits(write_reg_m, rt_e))
            ForwardBE = 2'b10;
        else if (reg_write_w && hits(write_reg_w, rt_e))
            ForwardBE = 2'b01;
    end

    always_comb begin
        ForwardAD    = reg_write_m && hits(write_reg_m, RsD);
        ForwardBD    = reg_write_m && hits(write_reg_m, RtD);

        d_hits_e     = hits(write_reg_e, RsD) || hits(write_reg_e, RtD);
        d_hits_m     = hits(write_reg_m, RsD) || hits(write_reg_m, RtD);

        lw_stall     = mem_to_reg_e && d_hits_e;
        branch_stall = BranchD && ((reg_write_e && d_hits_e) || (mem_to_reg_m && d_hits_m));
        stall        = lw_stall || branch_stall;

        StallF       = stall;
        StallD       = stall;
        FlushE       = stall;
    end

    // E/M/W never stall; a stall only turns the incoming E slot into a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_e         <= '0;
            rt_e         <= '0;
            write_reg_e  <= '0;
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            write_reg_m  <= '0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            write_reg_w  <= '0;
            reg_write_w  <= 1'b0;
        end else begin
            if (stall) begin
                rs_e         <= '0;
                rt_e         <= '0;
                write_reg_e  <= '0;
                reg_write_e  <= 1'b0;
                mem_to_reg_e <= 1'b0;
            end else begin
                rs_e         <= RsD;
                rt_e         <= RtD;
                write_reg_e  <= RegDstD ? RdD : RtD;
                reg_write_e  <= RegWriteD;
                mem_to_reg_e <= MemtoRegD;
            end
            write_reg_m  <= write_reg_e;
            reg_write_m  <= reg_write_e;
            mem_to_reg_m <= mem_to_reg_e;
            write_reg_w  <= write_reg_m;
            reg_write_w  <= reg_write_m;
        end
    end

endmodule
